micro_seq_ctrl: RTL and testbench
=================================

Name: micro_seq_ctrl

Overview:
- Clocked sequencer for the `micro_v` code decoder (ports `i_en`, `i_code[3:0]`, `o_A`, `o_L`, `o_B`).
- Accepts 4-bit codes from an upstream requester through a valid/ready handshake.
- Drives the decoder enable and code for a settle window, samples the decoder's A/L/B flags, and reports a registered result.
- Tracks consecutive failed attempts and enforces a timed lockout after too many failures or an L result.

Parameters:
- SETTLE_CYC, 2, cycles the decoder is driven (`o_en`=1) before its flags are sampled; legal range 1..15.
- MAX_FAIL, 3, consecutive failures that trigger lockout; legal range 1..15.
- LOCK_CYC, 8, lockout duration in cycles; legal range 1..255.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  requester presents a code.
- i_code  in  4  requested code.
- o_ready  out  1  controller can accept a code this cycle.
- i_unlock  in  1  synchronous override: ends lockout and clears the fail count.
- o_en  out  1  to decoder `i_en`.
- o_dec_code  out  4  to decoder `i_code`.
- i_A  in  1  from decoder `o_A` (accept).
- i_L  in  1  from decoder `o_L` (lock request).
- i_B  in  1  from decoder `o_B` (bad code).
- o_done  out  1  one-cycle pulse: result valid.
- o_result  out  2  00=ERR, 01=A, 10=L, 11=B; held until the next o_done.
- o_locked  out  1  high while in lockout.
- o_fail_cnt  out  4  current consecutive-failure count.

Behaviour:
- Reset (async assert, sync release): state=IDLE; o_en=0, o_dec_code=0, o_done=0, o_result=00, o_locked=0, o_fail_cnt=0. Internal counters=0. o_ready=1 from the first cycle after release.
- Reset mid-operation: abandons any transaction immediately; no o_done is emitted.
- FSM states: IDLE, DRIVE, RESULT, LOCKOUT.
- IDLE:
  - o_ready=1, o_en=0.
  - On i_valid&&o_ready: latch i_code into o_dec_code and go to DRIVE.
  - o_ready=0 in all other states.
- DRIVE:
  - o_en=1, o_dec_code stable.
  - Stays exactly SETTLE_CYC cycles.
  - On the last DRIVE cycle, register i_A/i_L/i_B, then go to RESULT.
- RESULT (one cycle):
  - o_en=0, o_done=1, o_result updated.
  - Classification: exactly one flag high selects A, L or B; zero or multiple flags high gives ERR.
  - Latency: handshake in cycle 0 gives o_done in cycle SETTLE_CYC+1. Back-to-back sustained throughput is one code per SETTLE_CYC+2 cycles.
- Fail counter, applied in RESULT:
  - A: clear to 0, go to IDLE.
  - L: clear to 0, go to LOCKOUT.
  - B or ERR: increment. If the new value equals MAX_FAIL, go to LOCKOUT; otherwise go to IDLE.
  - The counter never exceeds MAX_FAIL.
- LOCKOUT:
  - o_locked=1, o_en=0, o_ready=0; i_valid is ignored (no handshake).
  - Timer counts LOCK_CYC cycles.
  - On expiry: go to IDLE, o_fail_cnt=0, o_locked=0 on the next cycle.
- o_dec_code keeps its last value outside DRIVE.
- i_unlock:
  - In LOCKOUT: next cycle is IDLE with o_fail_cnt=0.
  - In IDLE or DRIVE: clears o_fail_cnt only.
  - In RESULT: unlock wins. The counter is cleared and LOCKOUT is not entered. o_done and o_result still report normally.
- Simultaneous i_valid and i_unlock in IDLE: both take effect (code accepted, counter cleared).

Test Plan:
- Reset, then 0011 with decoder returning A only → o_ready drops in cycle 1, o_en high cycles 1-2, o_done at cycle 3, o_result=01, o_fail_cnt=0.
- Three codes 1010/1011/0100 each returning B → o_fail_cnt 1,2, then o_locked=1 after the third o_done. o_ready=0 for 8 cycles, then o_ready=1 and o_fail_cnt=0.
- Code 1100 returning L → o_result=10, immediate lockout even with o_fail_cnt=0. i_valid during lockout is never acknowledged.
- Decoder flags A and B both high, then none high → o_result=00 twice and o_fail_cnt=2. Next code returning A → o_fail_cnt=0.
- o_fail_cnt=2, third B result with i_unlock high in the RESULT cycle → o_result=11, o_fail_cnt=0, no lockout. i_unlock in lockout cycle 3 → IDLE next cycle.
- Assert i_rst_n=0 mid-DRIVE → o_en=0 and o_dec_code=0 immediately, no o_done. After release, a 1111 request completes normally.

Source files
------------

// File: rtl/micro_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : micro_seq_ctrl
// Purpose  : Handshaked sequencer for the micro_v decoder with fail lockout.
// Revision : 1.0
// ============================================================================
module micro_seq_ctrl #(
  parameter int SETTLE_CYC = 2,
  parameter int MAX_FAIL   = 3,
  parameter int LOCK_CYC   = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [3:0] i_code,
  output logic       o_ready,
  input  logic       i_unlock,
  output logic       o_en,
  output logic [3:0] o_dec_code,
  input  logic       i_A,
  input  logic       i_L,
  input  logic       i_B,
  output logic       o_done,
  output logic [1:0] o_result,
  output logic       o_locked,
  output logic [3:0] o_fail_cnt
);

  localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] c_MAX_FAIL    = 4'(MAX_FAIL);
  localparam logic [7:0] c_LOCK_LAST   = 8'(LOCK_CYC - 1);

  localparam logic [1:0] c_RES_ERR = 2'b00;
  localparam logic [1:0] c_RES_A   = 2'b01;
  localparam logic [1:0] c_RES_L   = 2'b10;
  localparam logic [1:0] c_RES_B   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_RESULT  = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_dec_code;
  logic [3:0] r_settle_cnt;
  logic [7:0] r_lock_cnt;
  logic [3:0] r_fail_cnt;
  logic [1:0] r_result;

  logic       w_accept;
  logic       w_settle_last;
  logic       w_lock_last;
  logic [3:0] w_fail_inc;
  logic       w_fail_hit;
  logic [1:0] w_class;

  assign w_accept      = i_valid && (r_state == S_IDLE);
  assign w_settle_last = (r_settle_cnt == c_SETTLE_LAST);
  assign w_lock_last   = (r_lock_cnt == c_LOCK_LAST);
  assign w_fail_inc    = r_fail_cnt + 4'd1;
  assign w_fail_hit    = (w_fail_inc == c_MAX_FAIL);

  // One-hot flags classify; anything else is a decoder error.
  always_comb begin
    w_class = c_RES_ERR;
    case ({i_A, i_L, i_B})
      3'b100:  w_class = c_RES_A;
      3'b010:  w_class = c_RES_L;
      3'b001:  w_class = c_RES_B;
      default: w_class = c_RES_ERR;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    o_ready  = 1'b0;
    o_en     = 1'b0;
    o_done   = 1'b0;
    o_locked = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_next = S_DRIVE;
      end
      S_DRIVE: begin
        o_en = 1'b1;
        if (w_settle_last) w_next = S_RESULT;
      end
      S_RESULT: begin
        o_done = 1'b1;
        if (i_unlock)                w_next = S_IDLE;
        else if (r_result == c_RES_L) w_next = S_LOCKOUT;
        else if (r_result == c_RES_A) w_next = S_IDLE;
        else if (w_fail_hit)          w_next = S_LOCKOUT;
        else                          w_next = S_IDLE;
      end
      S_LOCKOUT: begin
        o_locked = 1'b1;
        if (i_unlock || w_lock_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dec_code   <= 4'd0;
      r_settle_cnt <= 4'd0;
      r_lock_cnt   <= 8'd0;
      r_result     <= c_RES_ERR;
    end else begin
      if (w_accept) r_dec_code <= i_code;
      r_settle_cnt <= (r_state == S_DRIVE) ? r_settle_cnt + 4'd1 : 4'd0;
      r_lock_cnt   <= (r_state == S_LOCKOUT) ? r_lock_cnt + 8'd1 : 8'd0;
      if ((r_state == S_DRIVE) && w_settle_last) r_result <= w_class;
    end
  end

  // Unlock clears the count in every state; it only ever reaches MAX_FAIL
  // on the way into lockout, which clears it again on exit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fail_cnt <= 4'd0;
    end else if (i_unlock) begin
      r_fail_cnt <= 4'd0;
    end else if (r_state == S_RESULT) begin
      if ((r_result == c_RES_A) || (r_result == c_RES_L)) r_fail_cnt <= 4'd0;
      else                                                r_fail_cnt <= w_fail_inc;
    end else if ((r_state == S_LOCKOUT) && w_lock_last) begin
      r_fail_cnt <= 4'd0;
    end
  end

  assign o_dec_code = r_dec_code;
  assign o_result   = r_result;
  assign o_fail_cnt = r_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_micro_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_micro_seq_ctrl
// Purpose  : Directed vector bench for micro_seq_ctrl with default parameters.
// Revision : 1.0
// ============================================================================
module tb_micro_seq_ctrl;

  localparam int SETTLE = 2;
  localparam int LOCK   = 8;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_valid;
  logic [3:0] i_code;
  logic       o_ready;
  logic       i_unlock;
  logic       o_en;
  logic [3:0] o_dec_code;
  logic       i_A, i_L, i_B;
  logic       o_done;
  logic [1:0] o_result;
  logic       o_locked;
  logic [3:0] o_fail_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  micro_seq_ctrl #(.SETTLE_CYC(SETTLE), .MAX_FAIL(3), .LOCK_CYC(LOCK)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_code(i_code),
    .o_ready(o_ready), .i_unlock(i_unlock), .o_en(o_en), .o_dec_code(o_dec_code),
    .i_A(i_A), .i_L(i_L), .i_B(i_B), .o_done(o_done), .o_result(o_result),
    .o_locked(o_locked), .o_fail_cnt(o_fail_cnt)
  );

  typedef struct {
    logic [3:0] code;
    logic       a, l, b;
    logic       unl_hs;
    logic       unl_res;
    logic [1:0] res;
    logic [3:0] fail;
    logic       lock;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Handshake in the current IDLE cycle; returns in the cycle after RESULT.
  task automatic run_txn(input string tag, input vec_t v);
    check({tag, " ready"}, {7'd0, o_ready}, 8'd1);
    i_valid = 1'b1; i_code = v.code; i_unlock = v.unl_hs;
    i_A = v.a; i_L = v.l; i_B = v.b;
    tick();
    i_valid = 1'b0; i_unlock = 1'b0; i_code = 4'h0;
    if (v.unl_hs) check({tag, " fail_hs"}, {4'd0, o_fail_cnt}, 8'd0);
    for (int k = 1; k <= SETTLE; k++) begin
      check({tag, " en"},    {7'd0, o_en},     8'd1);
      check({tag, " rdy0"},  {7'd0, o_ready},  8'd0);
      check({tag, " code"},  {4'd0, o_dec_code}, {4'd0, v.code});
      check({tag, " early"}, {7'd0, o_done},   8'd0);
      tick();
    end
    check({tag, " done"},   {7'd0, o_done},   8'd1);
    check({tag, " en_res"}, {7'd0, o_en},     8'd0);
    check({tag, " result"}, {6'd0, o_result}, {6'd0, v.res});
    i_unlock = v.unl_res;
    tick();
    i_unlock = 1'b0;
    check({tag, " done0"},  {7'd0, o_done},     8'd0);
    check({tag, " hold"},   {6'd0, o_result},   {6'd0, v.res});
    check({tag, " fail"},   {4'd0, o_fail_cnt}, {4'd0, v.fail});
    check({tag, " locked"}, {7'd0, o_locked},   {7'd0, v.lock});
  endtask

  // Entered in lockout cycle 1; i_valid is held to prove it is ignored.
  task automatic lockout_wait(input string tag, input logic [3:0] code);
    for (int k = 1; k <= LOCK; k++) begin
      i_valid = (k < LOCK);
      i_code  = 4'hF;
      check({tag, " lk"},    {7'd0, o_locked},   8'd1);
      check({tag, " lk_rdy"}, {7'd0, o_ready},   8'd0);
      check({tag, " lk_en"}, {7'd0, o_en},       8'd0);
      check({tag, " lk_code"}, {4'd0, o_dec_code}, {4'd0, code});
      tick();
    end
    i_valid = 1'b0;
    check({tag, " exit_rdy"},  {7'd0, o_ready},    8'd1);
    check({tag, " exit_lk"},   {7'd0, o_locked},   8'd0);
    check({tag, " exit_fail"}, {4'd0, o_fail_cnt}, 8'd0);
  endtask

  vec_t hv;

  initial begin
    //            code   a     l     b     uhs   ures  res    fail  lock
    vecs[0]  = '{4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd0, 1'b0};
    vecs[1]  = '{4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 4'd1, 1'b0};
    vecs[2]  = '{4'hB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 4'd2, 1'b0};
    vecs[3]  = '{4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 4'd3, 1'b1};
    vecs[4]  = '{4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 4'd0, 1'b1};
    vecs[5]  = '{4'h1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'd1, 1'b0};
    vecs[6]  = '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd2, 1'b0};
    vecs[7]  = '{4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd0, 1'b0};
    vecs[8]  = '{4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 4'd1, 1'b0};
    vecs[9]  = '{4'h6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 4'd1, 1'b0};
    vecs[10] = '{4'h8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 4'd2, 1'b0};
    vecs[11] = '{4'h9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 4'd0, 1'b0};
    vecs[12] = '{4'hD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd1, 1'b0};
    vecs[13] = '{4'hE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd2, 1'b0};

    i_rst_n = 1'b0; i_valid = 1'b0; i_code = 4'h0; i_unlock = 1'b0;
    i_A = 1'b0; i_L = 1'b0; i_B = 1'b0;
    tick(); tick();
    check("rst en",     {7'd0, o_en},       8'd0);
    check("rst code",   {4'd0, o_dec_code}, 8'd0);
    check("rst done",   {7'd0, o_done},     8'd0);
    check("rst result", {6'd0, o_result},   8'd0);
    check("rst locked", {7'd0, o_locked},   8'd0);
    check("rst fail",   {4'd0, o_fail_cnt}, 8'd0);
    #2 i_rst_n = 1'b1;
    tick();
    check("post-rst ready", {7'd0, o_ready}, 8'd1);

    for (int i = 0; i < 14; i++) begin
      run_txn($sformatf("v%0d", i), vecs[i]);
      if (vecs[i].lock) lockout_wait($sformatf("v%0d", i), vecs[i].code);
    end

    // Third failure locks out; unlock in lockout cycle 3 returns to IDLE.
    hv = '{4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 4'd3, 1'b1};
    run_txn("unl", hv);
    tick(); tick();
    check("unl lk3", {7'd0, o_locked}, 8'd1);
    i_unlock = 1'b1;
    tick();
    i_unlock = 1'b0;
    check("unl ready",  {7'd0, o_ready},    8'd1);
    check("unl locked", {7'd0, o_locked},   8'd0);
    check("unl fail",   {4'd0, o_fail_cnt}, 8'd0);

    // Raise the count, then reset mid-DRIVE: outputs clear at once, no o_done.
    hv = '{4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 4'd1, 1'b0};
    run_txn("pre-rst", hv);
    i_valid = 1'b1; i_code = 4'hF; i_A = 1'b1; i_L = 1'b0; i_B = 1'b0;
    tick();
    i_valid = 1'b0;
    check("mid en", {7'd0, o_en}, 8'd1);
    #2 i_rst_n = 1'b0;
    #1;
    check("mid-rst en",   {7'd0, o_en},       8'd0);
    check("mid-rst code", {4'd0, o_dec_code}, 8'd0);
    check("mid-rst fail", {4'd0, o_fail_cnt}, 8'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mid-rst done", {7'd0, o_done}, 8'd0);
    end
    i_rst_n = 1'b1;
    tick();
    check("rel done",  {7'd0, o_done},  8'd0);
    check("rel ready", {7'd0, o_ready}, 8'd1);
    hv = '{4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd0, 1'b0};
    run_txn("after-rst", hv);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
